// File: rtl/eth_tx_frame_arbiter.sv
// eth_tx_frame_arbiter
// Frame-granular round-robin arbiter that merges S_COUNT byte-wide AXI-stream
// sources onto the single MAC TX FIFO input. It grants one source per frame
// and never interleaves frames. It also truncates frames longer than
// MAX_FRAME_LEN, marks them bad, and discards the rest of the frame.
module eth_tx_frame_arbiter #(
    parameter int S_COUNT       = 4,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int CNT_WIDTH     = $clog2(MAX_FRAME_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [S_COUNT*8-1:0]       s_axis_tdata,
    input  logic [S_COUNT-1:0]         s_axis_tvalid,
    output logic [S_COUNT-1:0]         s_axis_tready,
    input  logic [S_COUNT-1:0]         s_axis_tlast,
    input  logic [S_COUNT-1:0]         s_axis_tuser,
    output logic [7:0]                 m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tuser,
    output logic [$clog2(S_COUNT)-1:0] grant,
    output logic                       busy,
    output logic                       stat_oversize
);

    localparam int GW = $clog2(S_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DISCARD
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [GW-1:0]        last_grant;
    logic [GW-1:0]        sel_src;
    logic                 any_valid;
    logic [CNT_WIDTH-1:0] beat_cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 hit_max;
    logic [7:0]           src_data [S_COUNT];
    logic [7:0]           cur_data;
    logic                 cur_last;
    logic                 cur_user;
    logic                 accept;

    genvar g;
    generate
        for (g = 0; g < S_COUNT; g++) begin : g_unpack
            assign src_data[g] = s_axis_tdata[g*8 +: 8];
        end
    endgenerate

    assign any_valid = |s_axis_tvalid;
    assign cur_data  = src_data[grant];
    assign cur_last  = s_axis_tlast[grant];
    assign cur_user  = s_axis_tuser[grant];
    assign accept    = s_axis_tvalid[grant] && s_axis_tready[grant];
    assign cnt_inc   = beat_cnt + CNT_WIDTH'(1);
    // The beat being accepted is number MAX_FRAME_LEN of the frame.
    assign hit_max   = (cnt_inc == CNT_WIDTH'(MAX_FRAME_LEN));

    // Round-robin search: first valid source above the last granted one, wrapping.
    always_comb begin
        logic found;
        int   idx;
        sel_src = last_grant;
        found   = 1'b0;
        idx     = 0;
        for (int i = 1; i <= S_COUNT; i++) begin
            idx = (int'(last_grant) + i) % S_COUNT;
            if (!found && s_axis_tvalid[GW'(idx)]) begin
                sel_src = GW'(idx);
                found   = 1'b1;
            end
        end
    end

    // Ready depends only on state, grant and the output register, never on tvalid.
    always_comb begin
        s_axis_tready = '0;
        case (state)
            PASS:    s_axis_tready[grant] = !m_axis_tvalid || m_axis_tready;
            DISCARD: s_axis_tready[grant] = 1'b1;
            default: s_axis_tready = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one arbitration cycle, then pass or drop until tlast.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_next = PASS;
                end
            end
            PASS: begin
                if (accept) begin
                    if (cur_last) begin
                        state_next = IDLE;
                    end else if (hit_max) begin
                        state_next = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (accept && cur_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Grant, rotation pointer, beat counter and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= '0;
            last_grant <= GW'(S_COUNT - 1);
            beat_cnt   <= '0;
            busy       <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant    <= sel_src;
                        beat_cnt <= '0;
                    end
                end
                PASS: begin
                    if (accept) begin
                        if (beat_cnt != CNT_WIDTH'(MAX_FRAME_LEN)) begin
                            beat_cnt <= cnt_inc;
                        end
                        if (cur_last) begin
                            last_grant <= grant;
                        end
                    end
                end
                DISCARD: begin
                    if (accept && cur_last) begin
                        last_grant <= grant;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output register: load on accepted PASS beat, otherwise drain when taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            stat_oversize <= 1'b0;
        end else begin
            stat_oversize <= 1'b0;
            if (state == PASS && accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= cur_data;
                m_axis_tlast  <= cur_last || hit_max;
                // A frame ending exactly at the limit is legal and keeps its own tuser.
                m_axis_tuser  <= (hit_max && !cur_last) ? 1'b1 : cur_user;
                stat_oversize <= hit_max && !cur_last;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed testbench for eth_tx_frame_arbiter (S_COUNT=4, MAX_FRAME_LEN=64).
module tb_eth_tx_frame_arbiter;

    localparam int S_COUNT = 4;
    localparam int MAXLEN  = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [S_COUNT*8-1:0] s_axis_tdata;
    logic [S_COUNT-1:0]   s_axis_tvalid;
    logic [S_COUNT-1:0]   s_axis_tready;
    logic [S_COUNT-1:0]   s_axis_tlast;
    logic [S_COUNT-1:0]   s_axis_tuser;
    logic [7:0]           m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 m_axis_tlast;
    logic                 m_axis_tuser;
    logic [1:0]           grant;
    logic                 busy;
    logic                 stat_oversize;

    always #5 clk = ~clk;

    eth_tx_frame_arbiter #(
        .S_COUNT      (S_COUNT),
        .MAX_FRAME_LEN(MAXLEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .grant        (grant),
        .busy         (busy),
        .stat_oversize(stat_oversize)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
        logic [3:0] src;
    } exp_t;

    exp_t exp_q[$];

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ovs_cnt  = 0;
    int   src_len  [S_COUNT];
    int   src_pos  [S_COUNT];
    bit   src_user [S_COUNT];
    bit   src_en   [S_COUNT];
    int   first_acc[S_COUNT];
    int   last_acc [S_COUNT];
    bit   rdy_mode    = 1'b0;
    bit   bp_chk      = 1'b0;
    bit   chk_grant   = 1'b0;
    bit   trunc_watch = 1'b0;
    bit   post_trunc  = 1'b0;
    bit   prev_stall  = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] beat_data(input int s, input int k);
        return 8'((s * 37 + k * 5 + 1) % 256);
    endfunction

    task automatic start_src(input int s, input int len, input bit user);
        src_len[s]   = len;
        src_pos[s]   = 0;
        src_user[s]  = user;
        src_en[s]    = 1'b1;
        first_acc[s] = -1;
        last_acc[s]  = -1;
    endtask

    // Expected output of one frame: cut to MAXLEN beats and marked bad when longer.
    task automatic push_frame(input int s, input int len, input bit user);
        int   nout;
        exp_t e;
        nout = (len > MAXLEN) ? MAXLEN : len;
        for (int k = 0; k < nout; k++) begin
            e.data = beat_data(s, k);
            e.last = (k == nout - 1);
            e.user = (k == nout - 1) && ((len > MAXLEN) || user);
            e.src  = 4'(s);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_inputs();
        bit v;
        for (int s = 0; s < S_COUNT; s++) begin
            v = src_en[s] && (src_pos[s] < src_len[s]);
            s_axis_tvalid[s]        = v;
            s_axis_tdata[s*8 +: 8]  = beat_data(s, src_pos[s]);
            s_axis_tlast[s]         = v && (src_pos[s] == src_len[s] - 1);
            s_axis_tuser[s]         = v && src_user[s] && (src_pos[s] == src_len[s] - 1);
        end
    endtask

    // One clock: drive at negedge, sample 1ns later, let the posedge happen, update model.
    task automatic tick();
        logic [S_COUNT-1:0] in_acc;
        exp_t e;
        drive_inputs();
        if (rdy_mode) m_axis_tready = ~m_axis_tready;
        else          m_axis_tready = 1'b1;
        #1;
        in_acc = s_axis_tvalid & s_axis_tready;
        if (prev_stall) begin
            check("stall_valid", m_axis_tvalid, 1);
            check("stall_data", m_axis_tdata, prev_data);
        end
        if (bp_chk && m_axis_tvalid && !m_axis_tready)
            check("bp_sready", s_axis_tready, 0);
        if (stat_oversize) begin
            ovs_cnt++;
            check("ovs_beat", {m_axis_tvalid, m_axis_tlast, m_axis_tuser}, 3'b111);
        end
        if (post_trunc)
            check("discard_quiet", m_axis_tvalid, 0);
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", m_axis_tdata, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("out_data", m_axis_tdata, e.data);
                check("out_last", m_axis_tlast, e.last);
                check("out_user", m_axis_tuser, e.user);
                if (chk_grant) check("out_grant", grant, e.src);
                if (trunc_watch && e.last && e.user) post_trunc = 1'b1;
            end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        @(posedge clk);
        for (int s = 0; s < S_COUNT; s++) begin
            if (in_acc[s]) begin
                src_pos[s]++;
                last_acc[s] = cyc;
                if (first_acc[s] < 0) first_acc[s] = cyc;
            end
        end
        if (post_trunc && src_pos[1] == src_len[1]) post_trunc = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    function automatic bit all_done();
        for (int s = 0; s < S_COUNT; s++)
            if (src_en[s] && src_pos[s] < src_len[s]) return 1'b0;
        return (exp_q.size() == 0) && !m_axis_tvalid;
    endfunction

    task automatic run(input int budget, input string tag);
        int n;
        n = 0;
        while (!all_done() && n < budget) begin
            tick();
            n++;
        end
        check(tag, all_done(), 1);
        for (int s = 0; s < S_COUNT; s++) src_en[s] = 1'b0;
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;
        for (int s = 0; s < S_COUNT; s++) begin
            src_en[s] = 1'b0; src_len[s] = 0; src_pos[s] = 0; src_user[s] = 1'b0;
            first_acc[s] = -1; last_acc[s] = -1;
        end
        @(negedge clk);
        tick();
        tick();

        // Reset state
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_ovs", stat_oversize, 0);
        check("rst_sready", s_axis_tready, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // Round-robin: four 64-beat frames (exactly the limit), order 0,1,2,3
        chk_grant = 1'b1;
        ovs_cnt   = 0;
        for (int s = 0; s < S_COUNT; s++) begin
            start_src(s, 64, 1'b0);
            push_frame(s, 64, 1'b0);
        end
        run(800, "rr_done");
        check("rr_gap01", first_acc[1] - last_acc[0], 2);
        check("rr_gap12", first_acc[2] - last_acc[1], 2);
        check("rr_gap23", first_acc[3] - last_acc[2], 2);
        check("rr_no_ovs", ovs_cnt, 0);
        check("rr_busy_end", busy, 0);

        // Priority rotation: 2 alone, then 1 and 3 together -> 3 before 1
        start_src(2, 5, 1'b0);
        push_frame(2, 5, 1'b0);
        run(100, "rot_a_done");
        start_src(3, 6, 1'b0);
        start_src(1, 6, 1'b1);
        push_frame(3, 6, 1'b0);
        push_frame(1, 6, 1'b1);
        run(100, "rot_b_done");
        check("rot_order", first_acc[3] < first_acc[1], 1);

        // Backpressure: output ready toggles every cycle during a 60-beat frame
        rdy_mode = 1'b1;
        bp_chk   = 1'b1;
        start_src(0, 60, 1'b0);
        push_frame(0, 60, 1'b0);
        run(400, "bp_done");
        rdy_mode   = 1'b0;
        bp_chk     = 1'b0;
        prev_stall = 1'b0;

        // Oversize: source 1 sends 80 beats while source 2 waits with a short frame
        ovs_cnt     = 0;
        trunc_watch = 1'b1;
        start_src(1, 80, 1'b0);
        start_src(2, 4, 1'b0);
        push_frame(1, 80, 1'b0);
        push_frame(2, 4, 1'b0);
        run(300, "ovs_done");
        trunc_watch = 1'b0;
        check("ovs_pulses", ovs_cnt, 1);
        check("ovs_in_consumed", src_pos[1], 80);
        check("ovs_next_arb", first_acc[2] - last_acc[1], 2);

        // Exact length: 64 beats, tuser=0, passes untouched
        ovs_cnt = 0;
        start_src(3, 64, 1'b0);
        push_frame(3, 64, 1'b0);
        run(200, "exact_done");
        check("exact_no_ovs", ovs_cnt, 0);

        // Reset mid-frame at beat 10 of a frame from source 2
        start_src(2, 30, 1'b0);
        push_frame(2, 30, 1'b0);
        n = 0;
        while (src_pos[2] < 10 && n < 100) begin
            tick();
            n++;
        end
        check("mid_beat10", src_pos[2], 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_tvalid", m_axis_tvalid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_grant", grant, 0);
        exp_q.delete();
        prev_stall = 1'b0;
        start_src(2, 8, 1'b0);
        push_frame(2, 8, 1'b0);
        run(100, "midrst_regrant");
        check("midrst_grant2", grant, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
